// File: rtl/s838_param_counter_pkg.sv
// s838_pkg: shared defaults and direction encoding for the parameterised counter
package s838_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 8;
  localparam logic UP = 1'b1;
  localparam logic DOWN = 1'b0;
endpackage

// File: rtl/s838_param_counter_carry_group.sv
// s838_carry_group: one GROUP-bit slice of the counter's carry-lookahead incrementer/decrementer
module s838_carry_group
  import s838_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] i_bits,
  input  logic             i_up,
  input  logic             i_en,
  output logic             o_ones,
  output logic             o_zeros,
  output logic [GROUP-1:0] o_bits
);
  logic w_t;
  assign o_ones  = &i_bits;
  assign o_zeros = ~|i_bits;
  // i_en is the AND of every lower group's detect, so a bit toggles when all lower bits propagate
  always_comb begin
    o_bits = i_bits;
    w_t = i_en;
    for (int i = 0; i < GROUP; i++) begin
      o_bits[i] = i_bits[i] ^ w_t;
      w_t = w_t & ((i_up == UP) ? i_bits[i] : ~i_bits[i]);
    end
  end
endmodule

// File: rtl/s838_param_counter.sv
// s838_param_counter: cascadable up/down modulo or saturating counter with group carry-lookahead
module s838_param_counter
  import s838_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP,
  parameter bit SAT   = 1'b0
) (
  input  logic             i_ck,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_cin,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_ld_val,
  input  logic [WIDTH-1:0] i_mod_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_cout,
  output logic             o_wrap
);
  localparam int NG = WIDTH / GROUP;
  logic [WIDTH-1:0] r_count, w_step_val, w_next;
  logic [NG-1:0]    w_gen;
  logic             w_step, w_term, r_wrap;
  assign w_gen[0] = 1'b1;
  genvar g;
  for (g = 0; g < NG; g++) begin : g_grp
    logic w_ones, w_zeros;
    s838_carry_group #(.GROUP(GROUP)) u_grp (
      .i_bits (r_count[g*GROUP +: GROUP]),
      .i_up   (i_up),
      .i_en   (w_gen[g]),
      .o_ones (w_ones),
      .o_zeros(w_zeros),
      .o_bits (w_step_val[g*GROUP +: GROUP])
    );
    if (g < NG - 1) begin : g_chain
      assign w_gen[g+1] = w_gen[g] & ((i_up == UP) ? w_ones : w_zeros);
    end
  end
  assign w_step = i_en & i_cin;
  assign w_term = (i_up == DOWN) ? (r_count == '0) : (r_count >= i_mod_val);
  assign o_cout = w_step & w_term;
  // saturating up at terminal lands on Mod_val, which also clamps a count above it
  always_comb begin
    w_next = w_term ? (SAT ? ((i_up == UP) ? i_mod_val : '0) : ((i_up == UP) ? '0 : i_mod_val)) : w_step_val;
  end
  always_ff @(posedge i_ck) begin
    r_count <= i_clear ? '0 : i_load ? i_ld_val : w_step ? w_next : r_count;
    r_wrap  <= ~i_clear & ~i_load & o_cout;
  end
  assign o_count = r_count;
  assign o_wrap  = r_wrap;
endmodule

// File: tb/tb_s838_param_counter.sv
// tb_s838_param_counter: table-driven scoreboard bench for modulo, saturating and cascaded counters
module tb_s838_param_counter;
  localparam int W = 8;
  localparam int G = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clear = 1'b1, load = 1'b0, en = 1'b0, cin = 1'b0, up = 1'b1;
  logic [W-1:0] ld_val = '0, mod_val = '0;
  logic [W-1:0] count, s_count;
  logic cout, s_cout, wrap, s_wrap;
  logic c_clear = 1'b1, c_en = 1'b0, one = 1'b1, zero = 1'b0;
  logic [W-1:0] zv = '0, ffv = '1;
  logic [W-1:0] lo_count, hi_count;
  logic lo_cout, hi_cout, lo_wrap, hi_wrap;

  s838_param_counter #(.WIDTH(W), .GROUP(G), .SAT(1'b0)) dut (
    .i_ck(clk), .i_clear(clear), .i_en(en), .i_cin(cin), .i_up(up), .i_load(load),
    .i_ld_val(ld_val), .i_mod_val(mod_val), .o_count(count), .o_cout(cout), .o_wrap(wrap));
  s838_param_counter #(.WIDTH(W), .GROUP(G), .SAT(1'b1)) dut_sat (
    .i_ck(clk), .i_clear(clear), .i_en(en), .i_cin(cin), .i_up(up), .i_load(load),
    .i_ld_val(ld_val), .i_mod_val(mod_val), .o_count(s_count), .o_cout(s_cout), .o_wrap(s_wrap));
  s838_param_counter #(.WIDTH(W), .GROUP(G), .SAT(1'b0)) dut_lo (
    .i_ck(clk), .i_clear(c_clear), .i_en(c_en), .i_cin(one), .i_up(one), .i_load(zero),
    .i_ld_val(zv), .i_mod_val(ffv), .o_count(lo_count), .o_cout(lo_cout), .o_wrap(lo_wrap));
  s838_param_counter #(.WIDTH(W), .GROUP(G), .SAT(1'b0)) dut_hi (
    .i_ck(clk), .i_clear(c_clear), .i_en(c_en), .i_cin(lo_cout), .i_up(one), .i_load(zero),
    .i_ld_val(zv), .i_mod_val(ffv), .o_count(hi_count), .o_cout(hi_cout), .o_wrap(hi_wrap));

  typedef struct {
    logic sat, clr, ld, en, cin, up;
    logic [7:0] ld_val, mod;
    logic ecout;
    logic [7:0] ecount;
    logic ewrap;
  } vec_t;
  typedef struct {
    int idx;
    logic sat;
    logic [7:0] count;
    logic wrap;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic add(input logic s, c, l, e, ci, u, input logic [7:0] lv, m,
                     input logic ec, input logic [7:0] ecnt, input logic ew);
    vec_t v;
    v.sat = s; v.clr = c; v.ld = l; v.en = e; v.cin = ci; v.up = u;
    v.ld_val = lv; v.mod = m; v.ecout = ec; v.ecount = ecnt; v.ewrap = ew;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic [15:0] cexp;
    logic wexp;
    // sat clr ld en cin up ld_val mod | cout count wrap
    add(0,1,0,0,0,1,8'h00,8'd9, 0,8'd0,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd1,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd2,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd3,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd4,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd5,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd6,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd7,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd8,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd9,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 1,8'd0,1);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd1,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd2,0);
    add(0,0,0,0,1,1,8'h00,8'd9, 0,8'd2,0);
    add(0,0,0,1,0,1,8'h00,8'd9, 0,8'd2,0);
    add(0,1,0,1,1,0,8'h00,8'd5, 0,8'd0,0);
    add(0,0,0,1,1,0,8'h00,8'd5, 1,8'd5,1);
    add(0,0,0,1,1,0,8'h00,8'd5, 0,8'd4,0);
    add(0,0,0,1,1,0,8'h00,8'd5, 0,8'd3,0);
    add(0,0,0,1,1,0,8'h00,8'd5, 0,8'd2,0);
    add(0,0,0,1,1,0,8'h00,8'd5, 0,8'd1,0);
    add(0,0,0,1,1,0,8'h00,8'd5, 0,8'd0,0);
    add(0,0,0,1,1,0,8'h00,8'd5, 1,8'd5,1);
    add(0,0,0,1,1,0,8'h00,8'd5, 0,8'd4,0);
    add(0,1,1,0,0,1,8'hF0,8'd9, 0,8'h00,0);
    add(0,0,1,0,0,1,8'hF0,8'd9, 0,8'hF0,0);
    add(0,0,0,1,1,1,8'h00,8'h10,1,8'h00,1);
    add(0,0,1,1,1,1,8'h33,8'h10,0,8'h33,0);
    add(0,0,0,1,1,1,8'h00,8'h10,1,8'h00,1);
    add(0,0,1,0,0,1,8'h0F,8'hFF,0,8'h0F,0);
    add(0,0,0,1,1,1,8'h00,8'hFF,0,8'h10,0);
    add(0,0,0,0,1,1,8'h00,8'hFF,0,8'h10,0);
    add(0,0,0,1,1,0,8'h00,8'hFF,0,8'h0F,0);
    add(0,0,1,0,0,1,8'hFF,8'hFF,0,8'hFF,0);
    add(0,0,0,1,1,1,8'h00,8'hFF,1,8'h00,1);
    add(0,0,0,1,1,0,8'h00,8'hFF,1,8'hFF,1);
    add(0,0,0,1,1,1,8'h00,8'h00,1,8'h00,1);
    add(0,0,0,1,1,1,8'h00,8'h00,1,8'h00,1);
    add(0,0,0,1,1,0,8'h00,8'h00,1,8'h00,1);
    add(0,0,1,0,0,1,8'h05,8'd9, 0,8'd5,0);
    add(0,0,0,1,1,1,8'h00,8'd9, 0,8'd6,0);
    add(0,0,0,1,1,0,8'h00,8'd9, 0,8'd5,0);
    add(1,1,0,0,0,1,8'h00,8'd3, 0,8'd0,0);
    add(1,0,0,1,1,1,8'h00,8'd3, 0,8'd1,0);
    add(1,0,0,1,1,1,8'h00,8'd3, 0,8'd2,0);
    add(1,0,0,1,1,1,8'h00,8'd3, 0,8'd3,0);
    add(1,0,0,1,1,1,8'h00,8'd3, 1,8'd3,1);
    add(1,0,0,1,1,1,8'h00,8'd3, 1,8'd3,1);
    add(1,0,0,1,1,0,8'h00,8'd3, 0,8'd2,0);
    add(1,0,0,1,1,0,8'h00,8'd3, 0,8'd1,0);
    add(1,0,0,1,1,0,8'h00,8'd3, 0,8'd0,0);
    add(1,0,0,1,1,0,8'h00,8'd3, 1,8'd0,1);
    add(1,0,1,0,0,1,8'h07,8'd3, 0,8'd7,0);
    add(1,0,0,1,1,1,8'h00,8'd3, 1,8'd3,1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clear = vecs[i].clr; load = vecs[i].ld; en = vecs[i].en; cin = vecs[i].cin;
      up = vecs[i].up; ld_val = vecs[i].ld_val; mod_val = vecs[i].mod;
      #1 chk("cout", i, vecs[i].sat ? s_cout : cout, vecs[i].ecout);
      sb.push_back('{i, vecs[i].sat, vecs[i].ecount, vecs[i].ewrap});
      @(posedge clk);
      #1 e = sb.pop_front();
      chk("count", e.idx, e.sat ? s_count : count, e.count);
      chk("wrap", e.idx, e.sat ? s_wrap : wrap, e.wrap);
    end
    @(negedge clk);
    c_clear = 1'b1;
    @(posedge clk);
    #1 chk("cascade_clear", 0, {hi_count, lo_count}, 16'h0000);
    @(negedge clk);
    c_clear = 1'b0;
    cexp = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      c_en = (n != 300);
      #1 chk("lo_cout", n, {hi_cout, lo_cout}, {1'b0, c_en && cexp[7:0] == 8'hFF});
      wexp = c_en && cexp[7:0] == 8'hFF;
      @(posedge clk);
      #1 if (c_en) cexp = cexp + 16'd1;
      chk("cascade", n, {hi_count, lo_count}, cexp);
      chk("cascade_wrap", n, {hi_wrap, lo_wrap}, {1'b0, wexp});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/s838_param_counter.md
S838_PARAM_COUNTER -- requirements
Module: s838_param_counter

Interface
REQ-001 Parameter WIDTH, default 32: counter width in bits, legal range 2..64.
REQ-002 Parameter GROUP, default 8: carry-lookahead group width in bits; WIDTH SHALL be a multiple of GROUP.
REQ-003 Parameter SAT, default 0: 0 = modulo wrap, 1 = saturate at the terminal value.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 CK  input  1  clock; all state updates on its rising edge.
REQ-006 Clear  input  1  synchronous active-high reset; highest priority.
REQ-007 En  input  1  count enable.
REQ-008 Cin  input  1  cascade carry-in; tie to 1 when not cascaded.
REQ-009 Up  input  1  direction: 1 = up, 0 = down.
REQ-010 Load  input  1  synchronous parallel load.
REQ-011 Ld_val  input  WIDTH  load value.
REQ-012 Mod_val  input  WIDTH  terminal value (up-count limit, down-count reload).
REQ-013 Count  output  WIDTH  registered counter state.
REQ-014 Cout  output  1  combinational cascade carry-out.
REQ-015 Wrap  output  1  registered one-cycle wrap/saturate event pulse.

Function
REQ-016 step SHALL be En AND Cin; Count SHALL hold when step = 0 and Load = 0.
REQ-017 Priority per cycle SHALL be Clear > Load > step; Load SHALL take effect regardless of En and Cin.
REQ-018 With Load = 1, Count SHALL become Ld_val on the next edge, and Wrap SHALL be 0.
REQ-019 The up terminal condition SHALL be Count >= Mod_val; the down terminal condition SHALL be Count == 0.
REQ-020 Up step, SAT = 0: non-terminal -> Count+1; terminal -> 0.
REQ-021 Down step, SAT = 0: non-terminal -> Count-1; terminal -> Mod_val.
REQ-022 With SAT = 1, a step at the terminal condition SHALL hold Count (up: Mod_val if Count > Mod_val, else unchanged; down: 0).
REQ-023 Cout SHALL equal step AND the terminal condition for the current Up value, with no register stage, so that chained instances advance in the same cycle.
REQ-024 Wrap SHALL be 1 in the cycle after any step taken at the terminal condition with Load = 0 and Clear = 0, and 0 otherwise.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; with Mod_val = 2^WIDTH-1 the block SHALL behave as a plain binary counter.
REQ-026 With Mod_val = 0: up mode SHALL hold 0, with Cout = step; down mode SHALL behave identically.
REQ-027 A change of Up mid-count SHALL take effect on the same edge, with no pipeline delay.
REQ-028 A change of Mod_val SHALL take effect immediately; if Count > Mod_val in up mode, the next step is terminal.
REQ-029 Increment SHALL use per-GROUP all-ones/all-zeros detect with group carry chaining, forming a group enable from the AND of the lower groups' detects.

Reset
REQ-030 On Clear = 1 at an edge, Count SHALL become 0 and Wrap 0, overriding Load and step.
REQ-031 Cout SHALL be 0 whenever step = 0, including during Clear.
REQ-032 Clear asserted mid-count SHALL lose no state other than Count; the first step after Clear deasserts SHALL follow REQ-020..REQ-022 from 0.

Structure
REQ-033 Shared package s838_pkg SHALL hold the default WIDTH/GROUP constants and the direction encoding constants UP = 1 and DOWN = 0.
REQ-034 Sub-module s838_carry_group (GROUP bits: all-ones, all-zeros, group toggle/enable) SHALL be instantiated WIDTH/GROUP times.
REQ-035 The block SHALL contain no latches, no asynchronous logic and no other clock.

Verification (WIDTH = 8, GROUP = 4)
REQ-036 Bench SHALL cover: Mod_val = 9, Up = 1, En = Cin = 1 for 12 cycles -> Count 0..9,0,1; Cout = 1 at Count = 9; Wrap = 1 on the cycle Count = 0.
REQ-037 Bench SHALL cover: Up = 0, Mod_val = 5, from 0 -> Count 5,4,3,2,1,0,5; Wrap pulses after each 0->5 transition.
REQ-038 Bench SHALL cover: SAT = 1, Up = 1, Mod_val = 3 -> Count 0,1,2,3,3,3; Wrap = 1 on each cycle after a step at 3.
REQ-039 Bench SHALL cover: Load = 1 with Ld_val = 0xF0 and Clear = 1 in the same cycle -> Count = 0; next cycle Load only -> Count = 0xF0; with Mod_val = 0x10 and Up, the next step -> 0.
REQ-040 Bench SHALL cover: two instances cascaded (Cout -> Cin, Mod_val = 0xFF) -> the 16-bit value increments continuously; low 0xFF->0x00 and high +1 occur on the same edge.
REQ-041 Bench SHALL cover: Mod_val = 0xFF, Count = 0x0F, step -> 0x10 (group carry); En = 0 with Cin = 1 -> hold, Cout = 0.
